// File: rtl/bird_physics.sv
// Bird vertical physics: frame tick, flap capture, and a
// velocity/position update sequenced over three clocks per tick.
module bird_physics #(
  parameter int Y_W      = 7,
  parameter int V_W      = 5,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 112,
  parameter int Y_START  = 56,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -4,
  parameter int V_MAX    = 6,
  parameter int TICK_DIV = 833333
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  move,
  input  logic                  press_key,
  output logic                  frame_tick,
  output logic [Y_W-1:0]        bird_y,
  output logic signed [V_W-1:0] velocity,
  output logic                  touched,
  output logic                  update_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = Y_W + 2;

  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);
  localparam logic [Y_W-1:0] Y_INIT = Y_W'(Y_START);
  localparam logic [Y_W-1:0] Y_LO = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] Y_HI = Y_W'(Y_MAX);

  localparam logic signed [SW-1:0] S_MIN = SW'(Y_MIN);
  localparam logic signed [SW-1:0] S_MAX = SW'(Y_MAX);

  localparam logic signed [V_W-1:0] V_G = V_W'(GRAVITY);
  localparam logic signed [V_W-1:0] V_FLAP = V_W'(FLAP_VEL);
  localparam logic signed [V_W-1:0] V_TOP = V_W'(V_MAX);

  typedef enum logic [1:0] {
    IDLE,
    CALC_V,
    CALC_Y,
    DONE
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [Y_W-1:0]        r_y;
  logic signed [V_W-1:0] r_vel;
  logic                  r_touch;
  logic                  r_done;
  logic                  r_pend;
  logic                  r_key_prev;

  logic                  w_tick;
  logic                  w_rise;
  logic signed [V_W-1:0] w_vinc;
  logic signed [V_W-1:0] w_vnext;
  logic signed [SW-1:0]  w_vext;
  logic signed [SW-1:0]  w_sum;

  assign w_tick = (r_cnt == C_LAST);
  assign w_rise = press_key & ~r_key_prev;

  // V_MAX + GRAVITY fits in V_W, so the add itself never wraps
  assign w_vinc  = r_vel + V_G;
  assign w_vnext = (w_vinc > V_TOP) ? V_TOP : w_vinc;

  assign w_vext = {{(SW-V_W){r_vel[V_W-1]}}, r_vel};
  assign w_sum  = $signed({2'b00, r_y}) + w_vext;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_y        <= Y_INIT;
      r_vel      <= '0;
      r_touch    <= 1'b0;
      r_done     <= 1'b0;
      r_pend     <= 1'b0;
      r_key_prev <= 1'b0;
    end else begin
      r_key_prev <= press_key;
      if (start) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_y     <= Y_INIT;
        r_vel   <= '0;
        r_touch <= 1'b0;
        r_done  <= 1'b0;
        r_pend  <= 1'b0;
      end else begin
        r_cnt  <= w_tick ? '0 : r_cnt + CW'(1);
        r_done <= 1'b0;
        if (r_state == CALC_V)
          r_pend <= w_rise;
        else if (w_rise)
          r_pend <= 1'b1;
        unique case (r_state)
          IDLE: begin
            if (w_tick && move)
              r_state <= CALC_V;
          end
          CALC_V: begin
            r_vel   <= r_pend ? V_FLAP : w_vnext;
            r_state <= CALC_Y;
          end
          CALC_Y: begin
            if (w_sum < S_MIN) begin
              r_y     <= Y_LO;
              r_vel   <= '0;
              r_touch <= 1'b1;
            end else if (w_sum > S_MAX) begin
              r_y     <= Y_HI;
              r_vel   <= '0;
              r_touch <= 1'b1;
            end else begin
              r_y <= Y_W'(w_sum);
            end
            r_done  <= 1'b1;
            r_state <= DONE;
          end
          DONE: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign frame_tick  = w_tick;
  assign bird_y      = r_y;
  assign velocity    = r_vel;
  assign touched     = r_touch;
  assign update_done = r_done;

endmodule

// File: tb/tb_bird_physics.sv
// Bench for bird_physics: directed scenarios plus random traffic
// against a frame-level reference model.
module tb_bird_physics;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic move = 1'b0;
  logic press_key = 1'b0;
  logic frame_tick;
  logic [6:0] bird_y;
  logic signed [4:0] velocity;
  logic touched;
  logic update_done;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_cnt = 0;
  int m_y = 56;
  int m_v = 0;
  int m_ph = 0;
  bit m_t = 0;
  bit m_pend = 0;
  bit m_kp = 0;
  bit m_ud = 0;

  always #5 clk = ~clk;

  bird_physics #(.TICK_DIV(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .move       (move),
    .press_key  (press_key),
    .frame_tick (frame_tick),
    .bird_y     (bird_y),
    .velocity   (velocity),
    .touched    (touched),
    .update_done(update_done)
  );

  function automatic logic [14:0] m_exp();
    logic [6:0] y;
    logic [4:0] v;
    y = 7'(m_y);
    v = 5'(m_v);
    return {y, v, m_t, (m_cnt == 7), m_ud};
  endfunction

  function automatic logic [14:0] dut_now();
    return {bird_y, velocity, touched, frame_tick, update_done};
  endfunction

  // model of one clock edge, from current inputs
  task automatic model_edge();
    bit rise;
    bit tick;
    int s;
    if (!resetn) begin
      m_cnt = 0; m_y = 56; m_v = 0; m_t = 0;
      m_pend = 0; m_kp = 0; m_ph = 0; m_ud = 0;
      return;
    end
    rise = press_key && !m_kp;
    m_kp = press_key;
    if (start) begin
      m_cnt = 0; m_y = 56; m_v = 0; m_t = 0;
      m_pend = 0; m_ph = 0; m_ud = 0;
      return;
    end
    tick = (m_cnt == 7);
    m_cnt = (m_cnt + 1) % 8;
    m_ud = 0;
    case (m_ph)
      0: begin
        if (tick && move) m_ph = 1;
        if (rise) m_pend = 1;
      end
      1: begin
        if (m_pend) m_v = -4;
        else m_v = (m_v + 1 > 6) ? 6 : m_v + 1;
        m_pend = rise;
        m_ph = 2;
      end
      2: begin
        s = m_y + m_v;
        if (s < 0) begin
          m_y = 0; m_v = 0; m_t = 1;
        end else if (s > 112) begin
          m_y = 112; m_v = 0; m_t = 1;
        end else begin
          m_y = s;
        end
        if (rise) m_pend = 1;
        m_ud = 1;
        m_ph = 3;
      end
      default: begin
        if (rise) m_pend = 1;
        m_ph = 0;
      end
    endcase
  endtask

  task automatic step(input bit r, input bit s,
                      input bit m, input bit k);
    resetn = r;
    start = s;
    move = m;
    press_key = k;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // kmode: 0 key low, 1 short press, 2 press and hold
  task automatic wait_upd(input bit mv, input int kmode,
                          output bit ok, output int lat);
    int since;
    bit k;
    since = -1;
    ok = 0;
    lat = -1;
    for (int i = 0; i < 24 && !ok; i++) begin
      k = (kmode == 2) || (kmode == 1 && i < 2);
      step(1, 0, mv, k);
      if (frame_tick) since = 0;
      else if (since >= 0) since++;
      if (update_done) begin
        ok = 1;
        lat = since;
      end
    end
  endtask

  task automatic test_reset();
    int ticks;
    bit ud;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_vec++;
    if (dut_now() !== {7'd56, 5'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset: got %h want %h",
               dut_now(), {7'd56, 5'd0, 3'b000});
    end
    ticks = 0;
    ud = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0);
      n_vec++;
      if (dut_now() !== m_exp()) begin
        n_err++;
        $display("FAIL idle[%0d]: got %h want %h",
                 i, dut_now(), m_exp());
      end
      if (frame_tick) ticks++;
      if (update_done) ud = 1;
    end
    n_vec++;
    if (ticks != 5) begin
      n_err++;
      $display("FAIL idle_ticks: got %0d want 5", ticks);
    end
    n_vec++;
    if (ud) begin
      n_err++;
      $display("FAIL idle_done: got 1 want 0");
    end
  endtask

  task automatic test_fall();
    int ev[3] = '{1, 2, 3};
    int ey[3] = '{57, 59, 62};
    bit ok;
    int lat;
    step(1, 1, 0, 0);
    n_vec++;
    if (dut_now() !== {7'd56, 5'd0, 3'b000}) begin
      n_err++;
      $display("FAIL start: got %h want %h",
               dut_now(), {7'd56, 5'd0, 3'b000});
    end
    for (int k = 0; k < 3; k++) begin
      wait_upd(1, 0, ok, lat);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL fall_timeout[%0d]: got none want update", k);
      end
      n_vec++;
      if (velocity !== ev[k] || bird_y !== ey[k]) begin
        n_err++;
        $display("FAIL fall[%0d]: got v=%0d y=%0d want v=%0d y=%0d",
                 k, velocity, bird_y, ev[k], ey[k]);
      end
      n_vec++;
      if (lat != 3) begin
        n_err++;
        $display("FAIL fall_lat[%0d]: got %0d want 3", k, lat);
      end
      n_vec++;
      if (dut_now() !== m_exp()) begin
        n_err++;
        $display("FAIL fall_model[%0d]: got %h want %h",
                 k, dut_now(), m_exp());
      end
    end
  endtask

  task automatic test_flap();
    bit ok;
    int lat;
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    wait_upd(1, 2, ok, lat);
    n_vec++;
    if (!ok || velocity !== -4 || bird_y !== 58) begin
      n_err++;
      $display("FAIL flap: got ok=%0d v=%0d y=%0d want 1 -4 58",
               ok, velocity, bird_y);
    end
    wait_upd(1, 2, ok, lat);
    n_vec++;
    if (!ok || velocity !== -3 || bird_y !== 55) begin
      n_err++;
      $display("FAIL flap_held: got ok=%0d v=%0d y=%0d want 1 -3 55",
               ok, velocity, bird_y);
    end
    step(1, 0, 1, 0);
    n_vec++;
    if (dut_now() !== m_exp()) begin
      n_err++;
      $display("FAIL flap_model: got %h want %h", dut_now(), m_exp());
    end
  endtask

  task automatic test_floor();
    bit ok;
    int lat;
    bit hit;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      wait_upd(1, 0, ok, lat);
      if (touched) hit = 1;
    end
    n_vec++;
    if (!hit || bird_y !== 112 || velocity !== 0) begin
      n_err++;
      $display("FAIL floor: got t=%0d y=%0d v=%0d want 1 112 0",
               hit, bird_y, velocity);
    end
    for (int i = 0; i < 2; i++) begin
      wait_upd(1, 0, ok, lat);
      n_vec++;
      if (touched !== 1'b1 || bird_y !== 112) begin
        n_err++;
        $display("FAIL floor_sticky[%0d]: got t=%0d y=%0d want 1 112",
                 i, touched, bird_y);
      end
    end
    step(1, 1, 0, 0);
    n_vec++;
    if (dut_now() !== {7'd56, 5'd0, 3'b000}) begin
      n_err++;
      $display("FAIL floor_start: got %h want %h",
               dut_now(), {7'd56, 5'd0, 3'b000});
    end
  endtask

  task automatic test_ceiling();
    bit ok;
    int lat;
    // 56 -> 57 -> 53 -> 50, then flaps down to 2
    wait_upd(1, 0, ok, lat);
    wait_upd(1, 1, ok, lat);
    wait_upd(1, 0, ok, lat);
    for (int i = 0; i < 12; i++) wait_upd(1, 1, ok, lat);
    n_vec++;
    if (bird_y !== 2 || touched !== 1'b0) begin
      n_err++;
      $display("FAIL ceil_pre: got y=%0d t=%0d want 2 0",
               bird_y, touched);
    end
    wait_upd(1, 1, ok, lat);
    n_vec++;
    if (bird_y !== 0 || velocity !== 0 || touched !== 1'b1) begin
      n_err++;
      $display("FAIL ceil_hit: got y=%0d v=%0d t=%0d want 0 0 1",
               bird_y, velocity, touched);
    end
    step(1, 1, 0, 0);
    for (int i = 0; i < 13; i++) wait_upd(1, 1, ok, lat);
    n_vec++;
    if (bird_y !== 4 || touched !== 1'b0) begin
      n_err++;
      $display("FAIL ceil_pre4: got y=%0d t=%0d want 4 0",
               bird_y, touched);
    end
    wait_upd(1, 1, ok, lat);
    n_vec++;
    if (bird_y !== 0 || velocity !== -4 || touched !== 1'b0) begin
      n_err++;
      $display("FAIL ceil_exact: got y=%0d v=%0d t=%0d want 0 -4 0",
               bird_y, velocity, touched);
    end
  endtask

  task automatic test_abort();
    bit seen;
    bit ud;
    // reset while the position update is in progress
    step(1, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      step(1, 0, 1, 0);
      if (frame_tick) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL abort_tick: got none want frame_tick");
    end
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    n_vec++;
    if (dut_now() !== {7'd56, 5'd0, 3'b000}) begin
      n_err++;
      $display("FAIL abort_reset: got %h want %h",
               dut_now(), {7'd56, 5'd0, 3'b000});
    end
    ud = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      if (update_done) ud = 1;
    end
    n_vec++;
    if (ud) begin
      n_err++;
      $display("FAIL abort_reset_done: got 1 want 0");
    end
    // start while the velocity update is in progress
    seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      step(1, 0, 1, 0);
      if (frame_tick) seen = 1;
    end
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    n_vec++;
    if (dut_now() !== {7'd56, 5'd0, 3'b000}) begin
      n_err++;
      $display("FAIL abort_start: got %h want %h",
               dut_now(), {7'd56, 5'd0, 3'b000});
    end
    ud = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      if (update_done) ud = 1;
    end
    n_vec++;
    if (ud) begin
      n_err++;
      $display("FAIL abort_start_done: got 1 want 0");
    end
  endtask

  task automatic test_random();
    bit r, s, m, k;
    k = 0;
    for (int i = 0; i < 1200; i++) begin
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 79) == 0);
      m = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) k = ~k;
      step(r, s, m, k);
      n_vec++;
      if (dut_now() !== m_exp()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h",
                 i, dut_now(), m_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_flap();
    test_floor();
    test_ceiling();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
